// File: rtl/l2_train_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_train_pkg
// Brief    : Shared types, window defaults and label decode for the L2 trainer
// Revision : 1.0
// ============================================================================
package l2_train_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_HOLD    = 3'd4,
        ST_CLEAR   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam int c_UPDATE_CLK = 11;
    localparam int c_WAIT_CLKS  = 12;

    // Decode width ceiling; label vectors are zero-extended to this size
    localparam int c_MAX_N = 64;
    localparam int c_IDX_W = 7;

    typedef struct packed {
        logic               valid;
        logic [c_IDX_W-1:0] idx;
    } onehot_t;

    function automatic onehot_t onehot_to_idx(input logic [c_MAX_N-1:0] vec);
        onehot_t     res;
        int unsigned cnt;
        res = '0;
        cnt = 0;
        for (int i = 0; i < c_MAX_N; i++) begin
            if (vec[i]) begin
                cnt++;
                res.idx = c_IDX_W'(i + 1);
            end
        end
        res.valid = (cnt == 1);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_win_latch.sv
`default_nettype none
// ============================================================================
// Module   : l2_win_latch
// Brief    : Winner OR-latch and first-nonzero label latch with sync clear
// Revision : 1.0
// ============================================================================
module l2_win_latch #(
    parameter int P_N = 10
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clear,
    input  logic           i_capture,
    input  logic [P_N-1:0] i_spike,
    input  logic [P_N-1:0] i_label,
    output logic [P_N-1:0] o_winner_nxt,
    output logic [P_N-1:0] o_label_nxt
);

    logic [P_N-1:0] r_winner;
    logic [P_N-1:0] r_label;

    // Next values are exported so the sequencer can decide in the last collect cycle
    always_comb begin
        o_winner_nxt = r_winner;
        o_label_nxt  = r_label;
        if (i_capture) begin
            o_winner_nxt = r_winner | i_spike;
            if (r_label == '0) begin
                o_label_nxt = i_label;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_winner <= '0;
            r_label  <= '0;
        end else begin
            r_winner <= o_winner_nxt;
            r_label  <= o_label_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_train_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : l2_train_sequencer
// Brief    : Per-sample window sequencer issuing L2 reward/punish updates
// Revision : 1.0
// ============================================================================
module l2_train_sequencer
    import l2_train_pkg::*;
#(
    parameter int P_N          = 10,
    parameter int P_S          = 5,
    parameter int P_UPDATE_CLK = c_UPDATE_CLK,
    parameter int P_WAIT_CLKS  = c_WAIT_CLKS,
    parameter int P_SAMPLES    = 1000,
    parameter int P_EPOCHS     = 8,
    localparam int c_UIDX_W    = $clog2(P_N + 1),
    localparam int c_SAMP_W    = (P_SAMPLES > 1) ? $clog2(P_SAMPLES) : 1,
    localparam int c_EPOCH_W   = (P_EPOCHS > 1) ? $clog2(P_EPOCHS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [P_S-1:0]       i_syncout,
    input  logic [P_N-1:0]       i_lv2_spikeout,
    input  logic [P_N-1:0]       i_label,
    output logic                 o_busy,
    output logic                 o_update_en,
    output logic                 o_update_reward,
    output logic [c_UIDX_W-1:0]  o_update_idx,
    output logic                 o_ts_capture,
    output logic                 o_clear,
    output logic                 o_endof_epochs,
    output logic [c_SAMP_W-1:0]  o_sample_cnt,
    output logic [c_EPOCH_W-1:0] o_epoch_cnt,
    output logic                 o_label_err
);

    localparam int c_WCNT_W = $clog2(P_WAIT_CLKS + 1);

    state_t               r_state;
    logic [c_WCNT_W-1:0]  r_wcnt;
    logic [c_SAMP_W-1:0]  r_sample;
    logic [c_EPOCH_W-1:0] r_epoch;

    logic                 w_sync;
    logic                 w_capture;
    logic [c_WCNT_W-1:0]  w_wcnt_inc;
    logic [P_N-1:0]       w_winner_nxt;
    logic [P_N-1:0]       w_label_nxt;
    onehot_t              w_oh;

    assign w_sync       = |i_syncout;
    assign w_capture    = ((r_state == ST_ARMED) && w_sync) || (r_state == ST_COLLECT);
    assign w_wcnt_inc   = r_wcnt + c_WCNT_W'(1);
    assign w_oh         = onehot_to_idx(c_MAX_N'(w_label_nxt));
    assign o_sample_cnt = r_sample;
    assign o_epoch_cnt  = r_epoch;

    l2_win_latch #(
        .P_N (P_N)
    ) u_latch (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (r_state == ST_CLEAR),
        .i_capture    (w_capture),
        .i_spike      (i_lv2_spikeout),
        .i_label      (i_label),
        .o_winner_nxt (w_winner_nxt),
        .o_label_nxt  (w_label_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_wcnt          <= '0;
            r_sample        <= '0;
            r_epoch         <= '0;
            o_busy          <= 1'b0;
            o_update_en     <= 1'b0;
            o_update_reward <= 1'b0;
            o_update_idx    <= '0;
            o_ts_capture    <= 1'b0;
            o_clear         <= 1'b0;
            o_endof_epochs  <= 1'b0;
            o_label_err     <= 1'b0;
        end else begin
            o_update_en     <= 1'b0;
            o_update_reward <= 1'b0;
            o_update_idx    <= '0;
            o_ts_capture    <= 1'b0;
            o_clear         <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state        <= ST_ARMED;
                        r_sample       <= '0;
                        r_epoch        <= '0;
                        o_busy         <= 1'b1;
                        o_endof_epochs <= 1'b0;
                        o_label_err    <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (w_sync) begin
                        r_state      <= ST_COLLECT;
                        r_wcnt       <= '0;
                        o_ts_capture <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    r_wcnt <= w_wcnt_inc;
                    if (w_wcnt_inc == c_WCNT_W'(P_UPDATE_CLK)) begin
                        r_state <= ST_UPDATE;
                        // Decision uses the latch contents including this final collect cycle
                        if (w_label_nxt != '0) begin
                            if (w_oh.valid) begin
                                o_update_en     <= 1'b1;
                                o_update_idx    <= c_UIDX_W'(w_oh.idx);
                                o_update_reward <= (w_winner_nxt == w_label_nxt);
                            end else begin
                                o_label_err <= 1'b1;
                            end
                        end
                    end
                end
                ST_UPDATE, ST_HOLD: begin
                    r_wcnt <= w_wcnt_inc;
                    if (w_wcnt_inc == c_WCNT_W'(P_WAIT_CLKS)) begin
                        r_state <= ST_CLEAR;
                        o_clear <= 1'b1;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_CLEAR: begin
                    r_state <= ST_ARMED;
                    if (r_sample == c_SAMP_W'(P_SAMPLES - 1)) begin
                        r_sample <= '0;
                        if (r_epoch == c_EPOCH_W'(P_EPOCHS - 1)) begin
                            r_state        <= ST_DONE;
                            o_busy         <= 1'b0;
                            o_endof_epochs <= 1'b1;
                        end else begin
                            r_epoch <= r_epoch + c_EPOCH_W'(1);
                        end
                    end else begin
                        r_sample <= r_sample + c_SAMP_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/l2_train_sequencer.md
# l2_train_sequencer

Synchronous controller that sequences the level-2 supervised training datapath, one sample window at a time. It detects the first input-sync event of a sample, collects the L2 winner and label over a fixed window, and issues one reward/punish update command to the weight/threshold update logic. It then clears the window and advances sample and epoch counters. It drives the end-of-epochs flag consumed by the L2 training and update logic, and sits between the L1 sync outputs, the L2 neuron array and that update logic.

## Interface
Parameters:
- P_N, 10, number of L2 neurons (label/spike width)
- P_S, 5, number of sync inputs from L1
- P_UPDATE_CLK, 11, window cycle at which the update command issues
- P_WAIT_CLKS, 12, window cycle at which the window closes (must be > P_UPDATE_CLK)
- P_SAMPLES, 1000, samples per epoch
- P_EPOCHS, 8, epochs per training run

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  begin or restart a training run (pulse)
- i_syncout  in  P_S  L1 sync events; any bit high opens a window
- i_lv2_spikeout  in  P_N  L2 spikes
- i_label  in  P_N  one-hot sample label; all-zero means no label
- o_busy  out  1  run in progress (state not IDLE/DONE)
- o_update_en  out  1  one-cycle update command
- o_update_reward  out  1  1 = reward (winner==label), 0 = punish; valid with o_update_en
- o_update_idx  out  $clog2(P_N+1)  1-based label neuron index; valid with o_update_en
- o_ts_capture  out  1  one-cycle pulse in the first COLLECT cycle; trace snapshot strobe
- o_clear  out  1  one-cycle window clear for downstream latches
- o_endof_epochs  out  1  level; run complete
- o_sample_cnt  out  $clog2(P_SAMPLES)  current sample
- o_epoch_cnt  out  $clog2(P_EPOCHS)  current epoch
- o_label_err  out  1  sticky; a latched label was not one-hot

## Operation
- States: IDLE, ARMED, COLLECT, UPDATE, HOLD, CLEAR, DONE. All outputs are Moore or registered.
- IDLE→ARMED on i_start. Sample and epoch counters are zeroed and o_label_err is cleared.
- ARMED→COLLECT when |i_syncout. The window counter wcnt is set to 0 in the first COLLECT cycle.
- wcnt increments every cycle in COLLECT, UPDATE and HOLD.
- Latching during the event cycle and COLLECT cycles:
  - The winner latch ORs in i_lv2_spikeout.
  - The label latch captures the first nonzero i_label; later labels are ignored.
  - Spikes and labels arriving in any other state are ignored.
- COLLECT→UPDATE when wcnt==P_UPDATE_CLK.
- UPDATE:
  - If the latched label is one-hot: o_update_en=1, o_update_idx=its bit position, o_update_reward=(winner==label), exact vector equality, so multiple winners mean punish.
  - If no label was latched: no update.
  - If the latched label is not one-hot: no update, and o_label_err is set.
- UPDATE→HOLD, or →CLEAR if wcnt+1==P_WAIT_CLKS.
- HOLD→CLEAR when wcnt==P_WAIT_CLKS.
- CLEAR pulses o_clear and resets the latches. Counter advance:
  - If sample==P_SAMPLES-1: sample←0 and epoch++.
  - If additionally epoch==P_EPOCHS-1: →DONE; otherwise →ARMED.
- DONE holds o_endof_epochs=1. i_start in DONE restarts the run: →ARMED, counters zeroed, o_endof_epochs←0.
- i_start outside IDLE/DONE is ignored.
- i_rst has priority over everything. On reset mid-window, no partial update is emitted.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: o_busy, o_update_en, o_update_reward, o_update_idx, o_ts_capture, o_clear, o_endof_epochs, counters, o_label_err.
- Event seen in ARMED at cycle E:
  - COLLECT covers E+1…E+P_UPDATE_CLK, with o_ts_capture at E+1.
  - UPDATE at E+P_UPDATE_CLK+1.
  - CLEAR at E+P_WAIT_CLKS+1.
  - Back in ARMED at E+P_WAIT_CLKS+2.
- Defaults (11/12): update at E+12, clear at E+13, re-armed at E+14.
- Sync events during COLLECT/UPDATE/HOLD/CLEAR do not open a new window.
- An event in the re-arm cycle does open one.
- o_endof_epochs rises the cycle after the final CLEAR.

## Structure
- Package l2_train_pkg holds:
  - the state enum;
  - the default window constants P_UPDATE_CLK and P_WAIT_CLKS;
  - the function onehot_to_idx(P_N), which returns the 1-based index and a valid flag.
- One sub-module: l2_win_latch, the winner OR-latch plus first-label latch with synchronous clear. The sequencer FSM and counters stay in the top.

## Test plan
- Reset mid-COLLECT (i_rst at E+5) → next cycle all outputs 0, state IDLE, no o_update_en ever.
- Single sample, P_SAMPLES=1: i_start, syncout=00001 at E, label=0000000100 at E+2, spike=0000000100 at E+4 → o_update_en=1, reward=1, idx=3 at E+12; o_clear at E+13; o_sample_cnt stays 0, o_epoch_cnt→1.
- Multiple winners (spike=0000000101), label=0000000100 → at E+12 reward=0, idx=3.
- No label in window → no o_update_en; o_clear at E+13; sample counter increments.
- Non-one-hot label 0000000110 → no update, o_label_err=1 sticky until next i_start.
- P_SAMPLES=2, P_EPOCHS=2: four windows → o_endof_epochs=1 after the 4th CLEAR; a further syncout is ignored; i_start in DONE restarts with counters 0.
